conv_maxpool: RTL and testbench

Streaming 2x2, stride-2 pooling stage placed directly downstream of the Conv block. It consumes Conv's raster-order `out_valid`/`out_data` feature-map stream and emits one pooled value per 2x2 window, also in raster order. It holds one half-row of horizontal partial results in a line buffer, so the frame streams through without stalls.

---
 rtl/conv_pkg.sv | 8 +
 rtl/pool_line_buf.sv | 21 ++
 rtl/conv_maxpool.sv | 135 +++++++++++++
 tb/tb_conv_maxpool.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared defaults and types for the Conv feature-map pipeline and its pooling stage.
package conv_pkg;
  localparam int DATA_W = 16;
  localparam int MAX_W  = 16;

  typedef enum logic [1:0] {IDLE, EVEN, ODD, SKIP} pool_state_t;
  typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_t;
endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for conv_maxpool: one horizontal max (or sum) per column pair.
module pool_line_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/conv_maxpool.sv
// Streaming 2x2 stride-2 pooling of Conv's raster feature map.
// Define MAXPOOL_AVG_EN to add the pool_mode_i port and the average-pooling datapath.
module conv_maxpool #(
  parameter int MAX_W  = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic [3:0]               map_size_i,
`ifdef MAXPOOL_AVG_EN
  input  logic                     pool_mode_i,
`endif
  output logic                     out_valid_o,
  output logic signed [DATA_W-1:0] out_data_o,
  output logic                     frame_done_o
);
  import conv_pkg::*;

  localparam int DEPTH = MAX_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MAXPOOL_AVG_EN
  localparam int BUF_W = DATA_W + 1;
`else
  localparam int BUF_W = DATA_W;
`endif

  pool_state_t              state_q;
  logic [3:0]               sz_q, col_q, row_q;
  logic signed [DATA_W-1:0] h0_q;
  logic [AW-1:0]            k;
  logic                     col_last, row_last, buf_we;
  logic signed [DATA_W-1:0] hmax, bmax, pooled_d;
  logic [BUF_W-1:0]         wdata_d, rdata;
`ifdef MAXPOOL_AVG_EN
  pool_mode_t               mode_q;
  logic [DATA_W:0]          hsum;
  logic [DATA_W+1:0]        psum;
`endif

  assign k        = AW'(col_q >> 1);
  assign col_last = (col_q == sz_q - 4'd1);
  assign row_last = (row_q == sz_q - 4'd1);
  assign buf_we   = in_valid_i && (state_q == EVEN) && col_q[0];
  assign hmax     = (in_data_i > h0_q) ? in_data_i : h0_q;
  assign bmax     = rdata[DATA_W-1:0];

  // Buffer write value and pooled result; the buffer entry is sign-extended so both modes share it.
  always_comb begin
    wdata_d  = BUF_W'(hmax);
    pooled_d = (hmax > bmax) ? hmax : bmax;
`ifdef MAXPOOL_AVG_EN
    hsum = {h0_q[DATA_W-1], h0_q} + {in_data_i[DATA_W-1], in_data_i};
    psum = {hsum[DATA_W], hsum} + {rdata[DATA_W], rdata};
    if (mode_q == POOL_AVG) begin
      wdata_d  = hsum;
      pooled_d = psum[DATA_W+1:2];
    end
`endif
  end

  pool_line_buf #(
    .DEPTH (DEPTH),
    .WIDTH (BUF_W),
    .AW    (AW)
  ) u_line_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (k),
    .wdata_i (wdata_d),
    .raddr_i (k),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sz_q         <= 4'd0;
      col_q        <= 4'd0;
      row_q        <= 4'd0;
      h0_q         <= '0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      frame_done_o <= 1'b0;
`ifdef MAXPOOL_AVG_EN
      mode_q       <= POOL_MAX;
`endif
    end else begin
      out_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      if (in_valid_i) begin
        if (state_q == IDLE) begin
          // The first sample of a frame is (row 0, col 0); a 1x1 map ends immediately.
          if (map_size_i >= 4'd2) begin
            sz_q    <= map_size_i;
            h0_q    <= in_data_i;
            col_q   <= 4'd1;
            row_q   <= 4'd0;
            state_q <= EVEN;
`ifdef MAXPOOL_AVG_EN
            mode_q  <= pool_mode_t'(pool_mode_i);
`endif
          end else if (map_size_i == 4'd1) begin
            frame_done_o <= 1'b1;
          end
        end else begin
          if (!col_q[0]) h0_q <= in_data_i;
          if (state_q == ODD && col_q[0]) begin
            out_valid_o <= 1'b1;
            out_data_o  <= pooled_d;
          end
          if (col_last) begin
            col_q <= 4'd0;
            if (row_last) begin
              state_q      <= IDLE;
              row_q        <= 4'd0;
              frame_done_o <= 1'b1;
            end else begin
              row_q <= row_q + 4'd1;
              // After an odd row, a lone remaining row (odd map) is consumed without output.
              case (state_q)
                EVEN:    state_q <= ODD;
                ODD:     state_q <= (row_q + 4'd2 == sz_q) ? SKIP : EVEN;
                default: state_q <= state_q;
              endcase
            end
          end else begin
            col_q <= col_q + 4'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_maxpool.sv
// Directed self-checking bench for conv_maxpool (max mode; average mode when MAXPOOL_AVG_EN is defined).
module tb_conv_maxpool;
  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic [3:0]         map_size;
`ifdef MAXPOOL_AVG_EN
  logic               pool_mode;
`endif
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               frame_done;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_maxpool #(.MAX_W(16), .DATA_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .map_size_i   (map_size),
`ifdef MAXPOOL_AVG_EN
    .pool_mode_i  (pool_mode),
`endif
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .frame_done_o (frame_done)
  );

  // One sample per call; returns 1 time unit after the consuming edge so registered outputs are visible.
  task automatic drive(input logic signed [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%0d done=%b, want 0/0/0", out_valid, out_data, frame_done);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_tiny_maps();
    map_size = 4'd0;
    drive(16'sd7);
    checks++;
    if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL size0_ignored: got done=%b valid=%b, want 0/0", frame_done, out_valid);
    end
    map_size = 4'd1;
    drive(16'sd7);
    checks++;
    if (frame_done !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL size1_done: got done=%b valid=%b, want 1/0", frame_done, out_valid);
    end
    idle(1);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL size1_pulse_width: got done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_max_4x4();
    int trig[4] = '{5, 7, 13, 15};
    logic signed [15:0] expv[4] = '{16'sd6, 16'sd8, 16'sd14, 16'sd16};
    int n = 0;
    map_size = 4'd4;
    for (int i = 0; i < 16; i++) begin
      drive(16'(i + 1));
      checks++;
      if (n < 4 && i == trig[n]) begin
        if (out_valid !== 1'b1 || out_data !== expv[n]) begin
          failures++;
          $display("[TB] FAIL max4x4_out i=%0d: got valid=%b data=%0d, want valid=1 data=%0d", i, out_valid, out_data, expv[n]);
        end
        n++;
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL max4x4_quiet i=%0d: got valid=%b, want 0", i, out_valid);
      end
      checks++;
      if (frame_done !== (i == 15)) begin
        failures++;
        $display("[TB] FAIL max4x4_done i=%0d: got %b, want %b", i, frame_done, (i == 15));
      end
    end
  endtask

  task automatic test_signed();
    int trig[4] = '{5, 7, 13, 15};
    logic signed [15:0] sw[4] = '{16'sh8000, 16'sd32767, 16'sh8000, 16'sh8000};
    int n = 0;
    map_size = 4'd4;
    for (int i = 0; i < 16; i++) begin
      drive(-16'sd5);
      checks++;
      if (n < 4 && i == trig[n]) begin
        if (out_valid !== 1'b1 || out_data !== -16'sd5) begin
          failures++;
          $display("[TB] FAIL neg_const_out i=%0d: got valid=%b data=%0d, want valid=1 data=-5", i, out_valid, out_data);
        end
        n++;
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL neg_const_quiet i=%0d: got valid=%b, want 0", i, out_valid);
      end
    end
    map_size = 4'd2;
    for (int i = 0; i < 4; i++) drive(sw[i]);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd32767 || frame_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL signed_extremes: got valid=%b data=%0d done=%b, want 1/32767/1", out_valid, out_data, frame_done);
    end
  endtask

  task automatic test_odd_5x5();
    int trig[4] = '{6, 8, 16, 18};
    logic signed [15:0] expv[4] = '{16'sd7, 16'sd9, 16'sd17, 16'sd19};
    int n = 0;
    map_size = 4'd5;
    for (int i = 0; i < 25; i++) begin
      drive(16'(i + 1));
      checks++;
      if (n < 4 && i == trig[n]) begin
        if (out_valid !== 1'b1 || out_data !== expv[n]) begin
          failures++;
          $display("[TB] FAIL odd5x5_out i=%0d: got valid=%b data=%0d, want valid=1 data=%0d", i, out_valid, out_data, expv[n]);
        end
        n++;
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL odd5x5_quiet i=%0d: got valid=%b, want 0", i, out_valid);
      end
      checks++;
      if (frame_done !== (i == 24)) begin
        failures++;
        $display("[TB] FAIL odd5x5_done i=%0d: got %b, want %b", i, frame_done, (i == 24));
      end
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd19 || frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL odd5x5_hold: got valid=%b data=%0d done=%b, want 0/19/0", out_valid, out_data, frame_done);
    end
  endtask

  task automatic test_gaps();
    int trig[4] = '{5, 7, 13, 15};
    logic signed [15:0] expv[4] = '{16'sd6, 16'sd8, 16'sd14, 16'sd16};
    int n = 0;
    int g;
    map_size = 4'd4;
    for (int i = 0; i < 16; i++) begin
      g = int'($urandom_range(0, 3));
      repeat (g) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL gaps_idle i=%0d: got valid=%b, want 0", i, out_valid);
        end
      end
      drive(16'(i + 1));
      checks++;
      if (n < 4 && i == trig[n]) begin
        if (out_valid !== 1'b1 || out_data !== expv[n]) begin
          failures++;
          $display("[TB] FAIL gaps_out i=%0d: got valid=%b data=%0d, want valid=1 data=%0d", i, out_valid, out_data, expv[n]);
        end
        n++;
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL gaps_quiet i=%0d: got valid=%b, want 0", i, out_valid);
      end
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL gaps_done: got %b, want 1", frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] d[8] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd9, -16'sd9, 16'sd0, 16'sd5};
    map_size = 4'd2;
    for (int i = 0; i < 8; i++) begin
      drive(d[i]);
      checks++;
      if (i == 3 || i == 7) begin
        if (out_valid !== 1'b1 || frame_done !== 1'b1 || out_data !== ((i == 3) ? 16'sd4 : 16'sd9)) begin
          failures++;
          $display("[TB] FAIL b2b_end i=%0d: got valid=%b done=%b data=%0d, want 1/1/%0d", i, out_valid, frame_done, out_data, (i == 3) ? 4 : 9);
        end
      end else if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_quiet i=%0d: got valid=%b done=%b, want 0/0", i, out_valid, frame_done);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] d[4] = '{16'sd3, -16'sd1, 16'sd7, 16'sd2};
    map_size = 4'd4;
    for (int i = 0; i < 9; i++) drive(16'(i + 1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got valid=%b data=%0d done=%b, want 0/0/0", out_valid, out_data, frame_done);
    end
    map_size = 4'd2;
    for (int i = 0; i < 4; i++) begin
      drive(d[i]);
      checks++;
      if (i == 3) begin
        if (out_valid !== 1'b1 || out_data !== 16'sd7 || frame_done !== 1'b1) begin
          failures++;
          $display("[TB] FAIL midreset_new_frame: got valid=%b data=%0d done=%b, want 1/7/1", out_valid, out_data, frame_done);
        end
      end else if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_quiet i=%0d: got valid=%b done=%b, want 0/0", i, out_valid, frame_done);
      end
    end
  endtask

`ifdef MAXPOOL_AVG_EN
  task automatic test_avg();
    logic signed [15:0] d[4] = '{-16'sd1, -16'sd2, -16'sd3, -16'sd1};
    map_size  = 4'd2;
    pool_mode = 1'b1;
    for (int i = 0; i < 4; i++) drive(d[i]);
    pool_mode = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== -16'sd2 || frame_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL avg_floor: got valid=%b data=%0d done=%b, want 1/-2/1", out_valid, out_data, frame_done);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    map_size = 4'd4;
`ifdef MAXPOOL_AVG_EN
    pool_mode = 1'b0;
`endif
    test_reset();
    test_tiny_maps();
    test_max_4x4();
    test_signed();
    test_odd_5x5();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
`ifdef MAXPOOL_AVG_EN
    test_avg();
`endif
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
